// File: rtl/hdmi_rx_pkg.sv
// Shared types for the HDMI data-island receive path: packet type codes,
// unpack FSM states, the stereo FIFO entry and the InfoFrame checksum.
package hdmi_rx_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } unpack_state_t;

    typedef struct packed {
        logic        block_start;
        logic [23:0] right;
        logic [23:0] left;
    } stereo_entry_t;

    // Mod-256 sum of the three header bytes and all 28 body bytes; zero means good.
    function automatic logic [7:0] infoframe_checksum(input logic [23:0]      header,
                                                      input logic [3:0][55:0] sub);
        logic [7:0] sum;
        sum = header[7:0] + header[15:8] + header[23:16];
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sum = sum + sub[i][8*j +: 8];
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/packet_sorter_if.sv
// Packet input and stereo audio output bundle of packet_sorter.
// Handshake: packet_valid is a one-cycle strobe with no back-pressure; audio
// transfers a word exactly on a cycle where audio_valid && audio_ready, and
// audio_valid/data stay stable until that transfer.
interface packet_sorter_if #(
    parameter int AUDIO_BIT_WIDTH = 16
);
    logic                             packet_valid;
    logic                             packet_error;
    logic [23:0]                      header;
    logic [3:0][55:0]                 sub;
    logic                             audio_valid;
    logic                             audio_ready;
    logic [1:0][AUDIO_BIT_WIDTH-1:0]  audio_sample_word;
    logic                             audio_block_start;

    modport master (
        output packet_valid, packet_error, header, sub, audio_ready,
        input  audio_valid, audio_sample_word, audio_block_start
    );

    modport slave (
        input  packet_valid, packet_error, header, sub, audio_ready,
        output audio_valid, audio_sample_word, audio_block_start
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO with a registered head: a written entry is visible on
// rd_data one cycle after the write; a pop on a full FIFO frees room for a same-cycle write.
module audio_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        valid_q, valid_d;
    logic [WIDTH-1:0]            data_q, data_d;
    logic                        do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = !valid_q;
    assign rd_data = data_q;
    assign do_pop  = rd_en && valid_q;
    assign do_push = wr_en && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        // Reading the next image of the array makes a write into an empty FIFO show up next cycle.
        valid_d = (count_d != '0);
        data_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: rtl/packet_sorter.sv
// Routes decoded HDMI data-island packets: audio samples into a stereo FIFO,
// ACR/AVI/Audio InfoFrame fields into status registers. Optional IEC 60958 parity check: PACKET_SORTER_PARITY_CHECK_EN.
module packet_sorter
    import hdmi_rx_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                clk_pixel,
    input  logic                reset,
    packet_sorter_if.slave      bus,
    output logic [19:0]         acr_n,
    output logic [19:0]         acr_cts,
    output logic                acr_update,
    output logic [6:0]          video_id_code,
    output logic                avi_update,
    output logic [2:0]          audio_channel_count,
    output logic                audio_info_update,
    output logic [3:0]          error_flags,
    output unpack_state_t       state_dbg
);
    localparam int ENTRY_W = 2 * AUDIO_BIT_WIDTH + 1;

    unpack_state_t    state_q, state_d;
    logic [3:0]       present_q, present_d, hold_b_q, hold_b_d;
    logic [3:0][55:0] hold_sub_q, hold_sub_d;
    logic [19:0]      acr_n_q, acr_n_d, acr_cts_q, acr_cts_d;
    logic             acr_update_q, acr_update_d, avi_update_q, avi_update_d;
    logic             info_update_q, info_update_d;
    logic [6:0]       vic_q, vic_d;
    logic [2:0]       cc_q, cc_d;
    logic [3:0]       flags_q, flags_d;

    logic               accept, pop, push, parity_ok, checksum_ok;
    logic               fifo_full, fifo_empty, unused_bits;
    logic [7:0]         hb0;
    logic [3:0]         present_in, b_in;
    logic [1:0]         idx;
    logic [55:0]        cur_sub;
    stereo_entry_t      cur_entry;
    logic [ENTRY_W-1:0] push_data, head;

    assign accept      = bus.packet_valid && !bus.packet_error;
    assign hb0         = bus.header[7:0];
    assign present_in  = bus.header[11:8];
    assign b_in        = bus.header[23:20];
    assign checksum_ok = (infoframe_checksum(bus.header, bus.sub) == 8'h00);
    assign pop         = bus.audio_valid && bus.audio_ready;

    // Lowest remaining present subpacket is the one unpacked this cycle.
    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (present_q[i]) idx = 2'(i);
        end
    end

    assign cur_sub   = hold_sub_q[idx];
    assign cur_entry = '{block_start: hold_b_q[idx], right: cur_sub[47:24], left: cur_sub[23:0]};
    assign push_data = {cur_entry.block_start,
                        cur_entry.right[23 -: AUDIO_BIT_WIDTH],
                        cur_entry.left[23 -: AUDIO_BIT_WIDTH]};
    assign unused_bits = ^{cur_entry, cur_sub[55:48]};

`ifdef PACKET_SORTER_PARITY_CHECK_EN
    assign parity_ok = !(^{cur_sub[23:0], cur_sub[51:48]}) && !(^{cur_sub[47:24], cur_sub[55:52]});
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        present_d     = present_q;
        hold_b_d      = hold_b_q;
        hold_sub_d    = hold_sub_q;
        acr_n_d       = acr_n_q;
        acr_cts_d     = acr_cts_q;
        vic_d         = vic_q;
        cc_d          = cc_q;
        acr_update_d  = 1'b0;
        avi_update_d  = 1'b0;
        info_update_d = 1'b0;
        flags_d       = flags_q;
        push          = 1'b0;

        if (state_q == UNPACK) begin
            present_d = present_q & ~(4'b0001 << idx);
            push      = parity_ok;
            if (!parity_ok) flags_d[2] = 1'b1;
            if (present_d == 4'b0000) state_d = IDLE;
            if (accept) flags_d[1] = 1'b1;
        end else if (accept) begin
            case (hb0)
                PKT_NULL: ;
                PKT_ACR: begin
                    acr_cts_d    = {bus.sub[0][11:8], bus.sub[0][23:16], bus.sub[0][31:24]};
                    acr_n_d      = {bus.sub[0][35:32], bus.sub[0][47:40], bus.sub[0][55:48]};
                    acr_update_d = 1'b1;
                end
                PKT_AUDIO_SAMPLE: begin
                    if (present_in != 4'b0000) begin
                        state_d    = UNPACK;
                        present_d  = present_in;
                        hold_b_d   = b_in;
                        hold_sub_d = bus.sub;
                    end
                end
                PKT_AVI, PKT_AUDIO_INFO: begin
                    if (!checksum_ok) begin
                        flags_d[3] = 1'b1;
                    end else if (hb0 == PKT_AVI) begin
                        vic_d        = bus.sub[0][38:32];
                        avi_update_d = 1'b1;
                    end else begin
                        cc_d          = bus.sub[0][10:8];
                        info_update_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (push && fifo_full && !pop) flags_d[0] = 1'b1;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q       <= IDLE;
            present_q     <= '0;
            hold_b_q      <= '0;
            hold_sub_q    <= '0;
            acr_n_q       <= '0;
            acr_cts_q     <= '0;
            vic_q         <= '0;
            cc_q          <= '0;
            acr_update_q  <= 1'b0;
            avi_update_q  <= 1'b0;
            info_update_q <= 1'b0;
            flags_q       <= '0;
        end else begin
            state_q       <= state_d;
            present_q     <= present_d;
            hold_b_q      <= hold_b_d;
            hold_sub_q    <= hold_sub_d;
            acr_n_q       <= acr_n_d;
            acr_cts_q     <= acr_cts_d;
            vic_q         <= vic_d;
            cc_q          <= cc_d;
            acr_update_q  <= acr_update_d;
            avi_update_q  <= avi_update_d;
            info_update_q <= info_update_d;
            flags_q       <= flags_d;
        end
    end

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk_pixel),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (bus.audio_ready),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (head)
    );

    assign bus.audio_valid          = !fifo_empty;
    assign bus.audio_block_start    = head[ENTRY_W-1];
    assign bus.audio_sample_word[1] = head[2*AUDIO_BIT_WIDTH-1:AUDIO_BIT_WIDTH];
    assign bus.audio_sample_word[0] = head[AUDIO_BIT_WIDTH-1:0];

    assign acr_n               = acr_n_q;
    assign acr_cts             = acr_cts_q;
    assign acr_update          = acr_update_q;
    assign video_id_code       = vic_q;
    assign avi_update          = avi_update_q;
    assign audio_channel_count = cc_q;
    assign audio_info_update   = info_update_q;
    assign error_flags         = flags_q;
    assign state_dbg           = state_q;
endmodule

// File: doc/packet_sorter.md
# packet_sorter

Receive-side counterpart of the data-island packet scheduler: accepts fully decoded (BCH-checked) HDMI data-island packets and routes them by header type. Audio Sample packets are unpacked into a stereo sample FIFO with a valid/ready output. ACR, AVI and Audio InfoFrame fields are latched into status registers. Null and unknown packets are discarded. The block sits between the data-island BCH decoder and the audio/video sink logic, entirely in the pixel clock domain.

## Interface
Parameters:
- AUDIO_BIT_WIDTH, 16: output sample width (16..24); the top bits of each 24-bit subframe sample are kept.
- FIFO_DEPTH, 8: stereo pairs buffered; power of two, minimum 4.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- packet_valid  in  1  one-cycle strobe; header/sub are valid this cycle.
- packet_error  in  1  BCH uncorrectable error on this packet; qualifies packet_valid.
- header  in  24  {HB2, HB1, HB0}.
- sub  in  [3:0][55:0]  subpackets; byte SBn occupies bits [8n+7:8n].
- audio_valid  out  1  FIFO head is valid.
- audio_ready  in  1  consumer accepts the head when audio_valid is high.
- audio_sample_word  out  [1:0][AUDIO_BIT_WIDTH-1:0]  [0] = left, [1] = right.
- audio_block_start  out  1  IEC 60958 B flag of the head sample.
- acr_n, acr_cts  out  20 each  last received ACR N and CTS values.
- acr_update  out  1  one-cycle pulse when new ACR values are latched.
- video_id_code  out  7  VIC from the last good AVI InfoFrame.
- avi_update  out  1  pulse.
- audio_channel_count  out  3  CC field from the last good Audio InfoFrame.
- audio_info_update  out  1  pulse.
- error_flags  out  4  sticky: {checksum_error, parity_error, packet_overrun, audio_overflow}.

## Operation
- A packet is accepted when packet_valid && !packet_error. A packet that carries packet_error is dropped silently.
- Dispatch is on HB0 = header[7:0]:
  - 0x00 (Null): ignored.
  - 0x01 (ACR): cts = {sub[0][11:8], sub[0][23:16], sub[0][31:24]}; n = {sub[0][35:32], sub[0][47:40], sub[0][55:48]}. Pulse acr_update.
  - 0x02 (Audio Sample): present = HB1[3:0]; B = HB2[7:4]. For each set bit i, in ascending order, push one entry: left = sub[i][23:0], right = sub[i][47:24], block_start = B[i]. The kept bits of each sample are [23:24-AUDIO_BIT_WIDTH].
  - 0x82 (AVI InfoFrame) and 0x84 (Audio InfoFrame): checksum = HB0 + HB1 + HB2 + all 28 body bytes, mod 256.
    - Checksum nonzero: set checksum_error and leave the latched fields unchanged.
    - Checksum zero, AVI: video_id_code = sub[0][38:32] (PB4); pulse avi_update.
    - Checksum zero, Audio: audio_channel_count = sub[0][10:8] (PB1); pulse audio_info_update.
  - Any other type: ignored.
- Unpack FSM, states IDLE and UNPACK:
  - IDLE → UNPACK on an accepted Audio Sample packet with present != 0. The packet is captured into a holding register.
  - UNPACK pushes one present subpacket per cycle and returns to IDLE after the last one.
  - An Audio Sample packet with present == 0 causes no transition.
- An accepted packet of any type that arrives while the FSM is in UNPACK is dropped and sets packet_overrun. The unpack in progress continues.
- A push while the FIFO is full drops that entry and sets audio_overflow. The remaining subpackets of the packet are still attempted.
- A simultaneous push and pop when the FIFO is full is allowed: the pop frees the slot, so the push succeeds.
- error_flags bits clear only on reset.

## Timing
- Reset values:
  - audio_valid = 0; all pulses = 0.
  - acr_n = 0, acr_cts = 0, video_id_code = 0, audio_channel_count = 0, error_flags = 0.
  - FSM = IDLE; FIFO empty.
- Reset asserted mid-UNPACK abandons the held packet and empties the FIFO.
- packet_valid in cycle t:
  - ACR/InfoFrame registers and their pulses update at t+1.
  - The first FIFO push occurs at t+1; the k-th present subpacket is pushed at t+k.
- FIFO output is registered: a pushed entry first appears with audio_valid = 1 one cycle after its push, so the earliest audio_valid is t+2.
- A pop occurs on audio_valid && audio_ready. With back-to-back ready, the FIFO sustains one pop per cycle.
- Sources space packets at least 32 cycles apart, so overrun indicates a protocol fault.

## Configuration
- PACKET_SORTER_PARITY_CHECK_EN defined:
  - Before pushing, check IEC 60958 even parity per channel: XOR of the 24 sample bits, V, U, C and P must be 0. Left flags are SB6[3:0] = {P,C,U,V}; right flags are SB6[7:4].
  - A failing subpacket is not pushed, sets parity_error, and still consumes its unpack cycle.
- Macro undefined: no parity logic; parity_error is tied to 0.

## Structure
- Package hdmi_rx_pkg holds:
  - packet type constants (NULL 0x00, ACR 0x01, AUDIO_SAMPLE 0x02, AVI 0x82, AUDIO_INFO 0x84);
  - the unpack-state enum;
  - the stereo-entry struct {block_start, right, left}.
- Sub-module audio_sample_fifo: synchronous FIFO parameterized by depth and entry width, with full, empty and a registered output.

## Test plan
- Packet with HB0=0x01, CTS 0x186A0, N 0x01800 → acr_cts=0x186A0 and acr_n=0x01800 at t+1; acr_update pulses once.
- Audio Sample packet with present=4'b1011, B=4'b0001, audio_ready held high → three pairs out in order sub 0, 1, 3; only the first has audio_block_start=1; first audio_valid at t+2.
- AVI InfoFrame VIC=16 with a correct checksum → video_id_code=16 and avi_update pulses. The same frame with PB0 incremented → checksum_error set and video_id_code stays 16.
- audio_ready held low, 3 full packets (12 pairs) with FIFO_DEPTH=8 → 8 pairs retained and audio_overflow set; later draining yields the first 8 pairs in order.
- Second audio packet at t+2 after one with present=4'b1111 → packet_overrun set; only the first 4 pairs appear. Reset asserted at t+3 of a new unpack → FIFO empty and no audio_valid afterwards.
- With PACKET_SORTER_PARITY_CHECK_EN, a subpacket with a flipped left P bit → that pair is not output and parity_error is set; neighbouring subpackets are output.
